mem_arbiter: RTL and testbench

//  Sits directly downstream of the per-thread LSUs. Accepts independent read/write

---
 rtl/mem_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that multiplexes LSU read/write requests onto external memory channels.
// Latency: mem valid 1 cycle after a granted consumer valid; consumer ready 1 cycle after mem ready.
// Backpressure: a channel holds its mem request until mem ready, then holds consumer ready until the LSU drops valid.
module mem_arbiter #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1,
    parameter int WRITE_ENABLE  = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]            mem_read_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
    input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
    output logic [NUM_CHANNELS-1:0]            mem_write_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
    output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
    input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);

    localparam int IW    = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
    localparam bit WR_EN = (WRITE_ENABLE != 0);

    typedef enum logic [2:0] {
        IDLE,
        READ_WAITING,
        WRITE_WAITING,
        RELAY_READ,
        RELAY_WRITE
    } state_t;

    state_t                 state_q [NUM_CHANNELS];
    state_t                 state_d [NUM_CHANNELS];
    logic [IW-1:0]          owner_q [NUM_CHANNELS];
    logic [IW-1:0]          owner_d [NUM_CHANNELS];
    logic [IW-1:0]          ptr_q   [NUM_CHANNELS];
    logic [IW-1:0]          ptr_d   [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]   addr_q  [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]   addr_d  [NUM_CHANNELS];
    logic [DATA_BITS-1:0]   wdata_q [NUM_CHANNELS];
    logic [DATA_BITS-1:0]   wdata_d [NUM_CHANNELS];
    logic [DATA_BITS-1:0]   rdata_q [NUM_CONSUMERS];
    logic [DATA_BITS-1:0]   rdata_d [NUM_CONSUMERS];
    logic [NUM_CHANNELS-1:0]  rvld_q, rvld_d, wvld_q, wvld_d;
    logic [NUM_CONSUMERS-1:0] rrdy_q, rrdy_d, wrdy_q, wrdy_d;
    logic [NUM_CONSUMERS-1:0] claim_q, claim_d;

    // unpacked views of the flattened buses
    logic [ADDR_BITS-1:0]   rd_addr   [NUM_CONSUMERS];
    logic [ADDR_BITS-1:0]   wr_addr   [NUM_CONSUMERS];
    logic [DATA_BITS-1:0]   wr_data   [NUM_CONSUMERS];
    logic [DATA_BITS-1:0]   mem_rdata [NUM_CHANNELS];
    logic [NUM_CONSUMERS-1:0] wr_req;
    logic [NUM_CHANNELS-1:0]  wr_ack;

    // scan scratch: taken accumulates claims so later channels see earlier grants this cycle
    logic [NUM_CONSUMERS-1:0] taken;
    logic                     found;
    logic [IW-1:0]            cand;
    logic [IW-1:0]            sel;

    assign wr_req = WR_EN ? consumer_write_valid : '0;
    assign wr_ack = WR_EN ? mem_write_ready : '0;

    for (genvar i = 0; i < NUM_CONSUMERS; i++) begin : g_lsu
        assign rd_addr[i] = consumer_read_address[i*ADDR_BITS +: ADDR_BITS];
        assign wr_addr[i] = consumer_write_address[i*ADDR_BITS +: ADDR_BITS];
        assign wr_data[i] = consumer_write_data[i*DATA_BITS +: DATA_BITS];
        assign consumer_read_data[i*DATA_BITS +: DATA_BITS] = rdata_q[i];
    end

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        assign mem_rdata[c] = mem_read_data[c*DATA_BITS +: DATA_BITS];
        assign mem_read_address[c*ADDR_BITS +: ADDR_BITS]  = addr_q[c];
        assign mem_write_address[c*ADDR_BITS +: ADDR_BITS] = WR_EN ? addr_q[c] : '0;
        assign mem_write_data[c*DATA_BITS +: DATA_BITS]    = WR_EN ? wdata_q[c] : '0;
    end

    assign consumer_read_ready  = rrdy_q;
    assign consumer_write_ready = wrdy_q;
    assign mem_read_valid       = rvld_q;
    assign mem_write_valid      = wvld_q;

    // next-state for all channels, evaluated in channel index order
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        rvld_d  = rvld_q;
        wvld_d  = wvld_q;
        rrdy_d  = rrdy_q;
        wrdy_d  = wrdy_q;
        claim_d = claim_q;
        taken   = claim_q;
        found   = 1'b0;
        cand    = '0;
        sel     = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            found = 1'b0;
            sel   = '0;
            case (state_q[c])
                IDLE: begin
                    for (int k = 0; k < NUM_CONSUMERS; k++) begin
                        cand = IW'((int'(ptr_q[c]) + k) % NUM_CONSUMERS);
                        if (!found && !taken[cand] && (consumer_read_valid[cand] || wr_req[cand])) begin
                            found = 1'b1;
                            sel   = cand;
                        end
                    end
                    if (found) begin
                        taken[sel]   = 1'b1;
                        claim_d[sel] = 1'b1;
                        owner_d[c]   = sel;
                        ptr_d[c]     = IW'((int'(sel) + 1) % NUM_CONSUMERS);
                        // read wins when an LSU presents both; the write is picked up next visit
                        if (consumer_read_valid[sel]) begin
                            addr_d[c]  = rd_addr[sel];
                            rvld_d[c]  = 1'b1;
                            state_d[c] = READ_WAITING;
                        end else begin
                            addr_d[c]  = wr_addr[sel];
                            wdata_d[c] = wr_data[sel];
                            wvld_d[c]  = 1'b1;
                            state_d[c] = WRITE_WAITING;
                        end
                    end
                end
                READ_WAITING: begin
                    if (mem_read_ready[c]) begin
                        rvld_d[c]              = 1'b0;
                        rrdy_d[owner_q[c]]     = 1'b1;
                        rdata_d[owner_q[c]]    = mem_rdata[c];
                        state_d[c]             = RELAY_READ;
                    end
                end
                RELAY_READ: begin
                    if (!consumer_read_valid[owner_q[c]]) begin
                        rrdy_d[owner_q[c]]  = 1'b0;
                        claim_d[owner_q[c]] = 1'b0;
                        state_d[c]          = IDLE;
                    end
                end
                WRITE_WAITING: begin
                    if (wr_ack[c]) begin
                        wvld_d[c]          = 1'b0;
                        wrdy_d[owner_q[c]] = 1'b1;
                        state_d[c]         = RELAY_WRITE;
                    end
                end
                RELAY_WRITE: begin
                    if (!wr_req[owner_q[c]]) begin
                        wrdy_d[owner_q[c]]  = 1'b0;
                        claim_d[owner_q[c]] = 1'b0;
                        state_d[c]          = IDLE;
                    end
                end
                default: state_d[c] = IDLE;
            endcase
        end
    end

    // state registers; reset drops any in-flight transaction without a ready
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state_q[c] <= IDLE;
                owner_q[c] <= '0;
                ptr_q[c]   <= '0;
                addr_q[c]  <= '0;
                wdata_q[c] <= '0;
            end
            for (int i = 0; i < NUM_CONSUMERS; i++) begin
                rdata_q[i] <= '0;
            end
            rvld_q  <= '0;
            wvld_q  <= '0;
            rrdy_q  <= '0;
            wrdy_q  <= '0;
            claim_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            rvld_q  <= rvld_d;
            wvld_q  <= wvld_d;
            rrdy_q  <= rrdy_d;
            wrdy_q  <= wrdy_d;
            claim_q <= claim_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: single-channel instance with an automatic memory responder,
// plus a two-channel instance driven by hand for the same-cycle grant case.
// Memory-side transactions are scoreboarded against expectations pushed at stimulus time.
module tb_mem_arbiter;

    typedef struct packed {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
    } txn_t;

    logic clk;
    logic reset;

    // single-channel instance
    logic [3:0]  c_rv, c_rr, c_wv, c_wr;
    logic [31:0] c_ra, c_rd, c_wa, c_wd;
    logic        m_rv, m_rr, m_wv, m_wr;
    logic [7:0]  m_ra, m_rd, m_wa, m_wd;

    // two-channel instance
    logic [3:0]  c_rv2, c_rr2, c_wr2;
    logic [31:0] c_ra2, c_rd2;
    logic [1:0]  m_rv2, m_rr2, m_wv2;
    logic [15:0] m_ra2, m_rd2, m_wa2, m_wd2;

    txn_t       exp_q[$];
    txn_t       obs_q[$];
    logic [7:0] mem_model [256];
    int rd_lat = 0;
    int wr_lat = 0;
    int rcnt, wcnt;
    int checks, failures;

    mem_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(1), .WRITE_ENABLE(1)) dut (
        .clk(clk), .reset(reset),
        .consumer_read_valid(c_rv), .consumer_read_address(c_ra),
        .consumer_read_ready(c_rr), .consumer_read_data(c_rd),
        .consumer_write_valid(c_wv), .consumer_write_address(c_wa),
        .consumer_write_data(c_wd), .consumer_write_ready(c_wr),
        .mem_read_valid(m_rv), .mem_read_address(m_ra),
        .mem_read_ready(m_rr), .mem_read_data(m_rd),
        .mem_write_valid(m_wv), .mem_write_address(m_wa),
        .mem_write_data(m_wd), .mem_write_ready(m_wr)
    );

    mem_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(2), .WRITE_ENABLE(1)) dut2 (
        .clk(clk), .reset(reset),
        .consumer_read_valid(c_rv2), .consumer_read_address(c_ra2),
        .consumer_read_ready(c_rr2), .consumer_read_data(c_rd2),
        .consumer_write_valid(4'b0), .consumer_write_address(32'h0),
        .consumer_write_data(32'h0), .consumer_write_ready(c_wr2),
        .mem_read_valid(m_rv2), .mem_read_address(m_ra2),
        .mem_read_ready(m_rr2), .mem_read_data(m_rd2),
        .mem_write_valid(m_wv2), .mem_write_address(m_wa2),
        .mem_write_data(m_wd2), .mem_write_ready(2'b00)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // memory responder for the single-channel instance: ready after *_lat waiting cycles
    initial begin
        m_rr = 1'b0; m_rd = 8'h0; m_wr = 1'b0; rcnt = 0; wcnt = 0;
        forever begin
            @(posedge clk); #1;
            m_rr = 1'b0;
            m_wr = 1'b0;
            if (m_rv) begin
                if (rcnt >= rd_lat) begin
                    m_rr = 1'b1;
                    m_rd = mem_model[m_ra];
                    obs_q.push_back({1'b0, m_ra, mem_model[m_ra]});
                    rcnt = 0;
                end else rcnt++;
            end else rcnt = 0;
            if (m_wv) begin
                if (wcnt >= wr_lat) begin
                    m_wr = 1'b1;
                    mem_model[m_wa] = m_wd;
                    obs_q.push_back({1'b1, m_wa, m_wd});
                    wcnt = 0;
                end else wcnt++;
            end else wcnt = 0;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        checks++; if ({m_rv, m_wv} !== 2'b00) begin failures++; $display("FAIL reset_mem_valid: got %b required 00", {m_rv, m_wv}); end
        checks++; if ({c_rr, c_wr} !== 8'h00) begin failures++; $display("FAIL reset_consumer_ready: got %h required 00", {c_rr, c_wr}); end
        checks++; if (c_rd !== 32'h0) begin failures++; $display("FAIL reset_read_data: got %h required 0", c_rd); end
        checks++; if ({m_ra, m_wa, m_wd} !== 24'h0) begin failures++; $display("FAIL reset_mem_bus: got %h required 0", {m_ra, m_wa, m_wd}); end
        checks++; if ({m_rv2, c_rr2} !== 6'h0) begin failures++; $display("FAIL reset_dut2: got %h required 0", {m_rv2, c_rr2}); end
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        int   hi;
        bit   got;
        txn_t e, o;
        hi = 0; got = 0; rd_lat = 2;
        c_ra[7:0] = 8'h10;
        c_rv[0]   = 1'b1;
        exp_q.push_back({1'b0, 8'h10, 8'hA5});
        @(negedge clk);
        checks++; if (m_rv !== 1'b0) begin failures++; $display("FAIL rd_early_valid: got %b required 0", m_rv); end
        @(negedge clk);
        checks++; if (m_rv !== 1'b1 || m_ra !== 8'h10) begin failures++; $display("FAIL rd_req: got valid %b addr %h required 1 10", m_rv, m_ra); end
        hi = 1;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (c_rr[0]) got = 1;
            else if (m_rv) hi++;
        end
        checks++; if (!got) begin failures++; $display("FAIL rd_timeout: got no read_ready required read_ready[0]"); end
        checks++; if (hi !== 3) begin failures++; $display("FAIL rd_hold: got %0d valid cycles required 3", hi); end
        checks++; if (c_rr !== 4'b0001 || c_rd[7:0] !== 8'hA5) begin failures++; $display("FAIL rd_data: got ready %b data %h required 0001 a5", c_rr, c_rd[7:0]); end
        checks++;
        if (obs_q.size() == 0 || exp_q.size() == 0) begin failures++; $display("FAIL rd_sb: got %0d observed required 1", obs_q.size()); end
        else begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            if (o !== e) begin failures++; $display("FAIL rd_sb: got %h required %h", o, e); end
        end
        tick();
        checks++; if (c_rr[0] !== 1'b1) begin failures++; $display("FAIL rd_ready_held: got %b required 1", c_rr[0]); end
        c_rv[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (c_rr[0] !== 1'b0 || m_rv !== 1'b0) begin failures++; $display("FAIL rd_ready_clear: got ready %b valid %b required 0 0", c_rr[0], m_rv); end
    endtask

    task automatic test_single_write();
        int   hi;
        bit   got;
        txn_t e, o;
        hi = 0; got = 0; wr_lat = 1;
        tick();
        c_wa[23:16] = 8'h22;
        c_wd[23:16] = 8'h3C;
        c_wv[2]     = 1'b1;
        exp_q.push_back({1'b1, 8'h22, 8'h3C});
        @(posedge clk);
        @(negedge clk);
        checks++; if (m_wv !== 1'b1 || m_wa !== 8'h22 || m_wd !== 8'h3C) begin failures++; $display("FAIL wr_req: got %b %h %h required 1 22 3c", m_wv, m_wa, m_wd); end
        checks++; if (m_rv !== 1'b0) begin failures++; $display("FAIL wr_no_read: got %b required 0", m_rv); end
        hi = 1;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (c_wr[2]) got = 1;
            else if (m_wv) hi++;
        end
        checks++; if (!got) begin failures++; $display("FAIL wr_timeout: got no write_ready required write_ready[2]"); end
        checks++; if (hi !== 2) begin failures++; $display("FAIL wr_hold: got %0d valid cycles required 2", hi); end
        checks++; if (c_wr !== 4'b0100 || m_wv !== 1'b0) begin failures++; $display("FAIL wr_ready: got %b valid %b required 0100 0", c_wr, m_wv); end
        checks++;
        if (obs_q.size() == 0 || exp_q.size() == 0) begin failures++; $display("FAIL wr_sb: got %0d observed required 1", obs_q.size()); end
        else begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            if (o !== e) begin failures++; $display("FAIL wr_sb: got %h required %h", o, e); end
        end
        tick();
        checks++; if (c_wr[2] !== 1'b1) begin failures++; $display("FAIL wr_ready_held: got %b required 1", c_wr[2]); end
        c_wv[2] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (c_wr !== 4'b0000) begin failures++; $display("FAIL wr_ready_clear: got %b required 0000", c_wr); end
    endtask

    task automatic test_round_robin();
        logic [3:0] masks [3];
        int         nreq  [3];
        int         ord   [3][4];
        logic [3:0] done;
        logic [7:0] a;
        txn_t       e, o;
        masks = '{4'hF, 4'h1, 4'h3};
        nreq  = '{4, 1, 2};
        ord   = '{'{0, 1, 2, 3}, '{0, 0, 0, 0}, '{1, 0, 0, 0}};
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        rd_lat = 0;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) c_ra[i*8 +: 8] = 8'(8'h40 + i);
            for (int j = 0; j < nreq[r]; j++) begin
                a = 8'(8'h40 + ord[r][j]);
                exp_q.push_back({1'b0, a, mem_model[a]});
            end
            c_rv = masks[r];
            done = 4'b0;
            for (int n = 0; n < 60 && done !== masks[r]; n++) begin
                @(negedge clk);
                for (int i = 0; i < 4; i++) begin
                    if (c_rv[i] && c_rr[i]) begin
                        a = 8'(8'h40 + i);
                        checks++;
                        if (c_rd[i*8 +: 8] !== mem_model[a]) begin failures++; $display("FAIL rr_data lsu%0d: got %h required %h", i, c_rd[i*8 +: 8], mem_model[a]); end
                        done[i] = 1'b1;
                    end
                end
                tick();
                c_rv = c_rv & ~done;
            end
            checks++; if (done !== masks[r]) begin failures++; $display("FAIL rr_timeout round%0d: got %b required %b", r, done, masks[r]); end
            for (int j = 0; j < nreq[r]; j++) begin
                checks++;
                if (obs_q.size() == 0 || exp_q.size() == 0) begin failures++; $display("FAIL rr_order round%0d: got no grant required grant %0d", r, j); end
                else begin
                    e = exp_q.pop_front(); o = obs_q.pop_front();
                    if (o !== e) begin failures++; $display("FAIL rr_order round%0d: got %h required %h", r, o, e); end
                end
            end
            tick();
            tick();
        end
    endtask

    task automatic test_two_channels();
        c_ra2 = {8'h00, 8'h00, 8'h51, 8'h50};
        c_rv2 = 4'b0011;
        @(posedge clk);
        @(negedge clk);
        checks++; if (m_rv2 !== 2'b11) begin failures++; $display("FAIL ch2_valid: got %b required 11", m_rv2); end
        checks++; if (m_ra2 !== 16'h5150) begin failures++; $display("FAIL ch2_addr: got %h required 5150", m_ra2); end
        tick();
        m_rr2 = 2'b11;
        m_rd2 = 16'hB2B1;
        tick();
        m_rr2 = 2'b00;
        @(negedge clk);
        checks++; if (c_rr2 !== 4'b0011 || m_rv2 !== 2'b00) begin failures++; $display("FAIL ch2_ready: got %b valid %b required 0011 00", c_rr2, m_rv2); end
        checks++; if (c_rd2[15:0] !== 16'hB2B1) begin failures++; $display("FAIL ch2_data: got %h required b2b1", c_rd2[15:0]); end
        tick();
        c_rv2 = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        checks++; if (c_rr2 !== 4'b0000 || m_rv2 !== 2'b00) begin failures++; $display("FAIL ch2_release: got %b %b required 0000 00", c_rr2, m_rv2); end
    endtask

    task automatic test_reset_mid();
        bit   got;
        txn_t e, o;
        got = 0;
        rd_lat = 50;
        c_ra[15:8] = 8'h60;
        c_rv[1]    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (m_rv !== 1'b1) begin failures++; $display("FAIL mid_waiting: got %b required 1", m_rv); end
        tick();
        reset = 1'b0;
        c_rv  = 4'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if ({m_rv, m_wv, c_rr, c_wr} !== 10'h0) begin failures++; $display("FAIL mid_reset_outputs: got %h required 0", {m_rv, m_wv, c_rr, c_wr}); end
        checks++; if (obs_q.size() !== 0) begin failures++; $display("FAIL mid_dropped: got %0d accepted required 0", obs_q.size()); end
        tick();
        reset  = 1'b1;
        rd_lat = 0;
        exp_q.delete();
        obs_q.delete();
        tick();
        c_ra[15:8] = 8'h61;
        c_rv[1]    = 1'b1;
        exp_q.push_back({1'b0, 8'h61, mem_model[8'h61]});
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (c_rr[1]) got = 1;
        end
        checks++; if (!got || c_rd[15:8] !== mem_model[8'h61]) begin failures++; $display("FAIL mid_after: got ready %b data %h required 1 %h", got, c_rd[15:8], mem_model[8'h61]); end
        checks++;
        if (obs_q.size() == 0 || exp_q.size() == 0) begin failures++; $display("FAIL mid_sb: got %0d observed required 1", obs_q.size()); end
        else begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            if (o !== e) begin failures++; $display("FAIL mid_sb: got %h required %h", o, e); end
        end
        tick();
        c_rv[1] = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_read_write_same();
        bit   both, rd_done, wr_done, order_ok;
        txn_t e, o;
        both = 0; rd_done = 0; wr_done = 0; order_ok = 1;
        rd_lat = 1;
        wr_lat = 1;
        c_ra[31:24] = 8'h70;
        c_wa[31:24] = 8'h71;
        c_wd[31:24] = 8'h99;
        exp_q.push_back({1'b0, 8'h70, mem_model[8'h70]});
        exp_q.push_back({1'b1, 8'h71, 8'h99});
        c_rv[3] = 1'b1;
        c_wv[3] = 1'b1;
        for (int n = 0; n < 60 && !(rd_done && wr_done); n++) begin
            @(negedge clk);
            if (m_rv && m_wv) both = 1;
            if (c_rv[3] && c_rr[3]) begin
                checks++;
                if (c_rd[31:24] !== mem_model[8'h70]) begin failures++; $display("FAIL rw_data: got %h required %h", c_rd[31:24], mem_model[8'h70]); end
                rd_done = 1;
            end
            if (c_wv[3] && c_wr[3]) begin
                wr_done = 1;
                if (!rd_done) order_ok = 0;
            end
            tick();
            if (rd_done) c_rv[3] = 1'b0;
            if (wr_done) c_wv[3] = 1'b0;
        end
        checks++; if (!(rd_done && wr_done)) begin failures++; $display("FAIL rw_timeout: got rd %b wr %b required 1 1", rd_done, wr_done); end
        checks++; if (both) begin failures++; $display("FAIL rw_overlap: got both valids high required never"); end
        checks++; if (!order_ok) begin failures++; $display("FAIL rw_order: got write before read required read first"); end
        for (int j = 0; j < 2; j++) begin
            checks++;
            if (obs_q.size() == 0 || exp_q.size() == 0) begin failures++; $display("FAIL rw_sb: got no transaction required entry %0d", j); end
            else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o !== e) begin failures++; $display("FAIL rw_sb: got %h required %h", o, e); end
            end
        end
        tick();
        tick();
        checks++; if ({c_rr, c_wr} !== 8'h00) begin failures++; $display("FAIL rw_release: got %h required 00", {c_rr, c_wr}); end
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b0;
        c_rv = 4'b0; c_ra = 32'h0; c_wv = 4'b0; c_wa = 32'h0; c_wd = 32'h0;
        c_rv2 = 4'b0; c_ra2 = 32'h0; m_rr2 = 2'b00; m_rd2 = 16'h0;
        for (int i = 0; i < 256; i++) mem_model[i] = 8'(i ^ 8'h5A);
        mem_model[8'h10] = 8'hA5;
        test_reset();
        test_single_read();
        test_single_write();
        test_round_robin();
        test_two_channels();
        test_reset_mid();
        test_read_write_same();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
